reaction_round_sequencer: RTL

//  Sequences the reaction-timer datapath (BCD millisecond counter, LFSR random delay) over a multi-round session.

---
 rtl/reaction_round_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/reaction_round_sequencer.sv
// Purpose : session/round sequencer for the reaction timer (delay, timing, false start, best time).
// Latency : every transition and captured value is registered; it shows one CLK after the qualifying input.
// Backpr. : none; btn_press/tick_1k are single-cycle pulses, ignored in states that do not use them.
//
// Ports
//   CLK, RST               clock, synchronous active-high reset
//   tick_1k, btn_press     1 kHz enable pulse, debounced press pulse
//   rand_val, bcd_time     LFSR value (sampled on entering DELAY), live BCD counter value
//   cnt_go, cnt_clear      BCD counter control
//   stim_led               "react now" indicator
//   state_o, round_o       current state code and round number (0 in IDLE)
//   last_time, best_time   last captured round time and session best (BCD)
//   false_start, miss      in FALSE state / last round ended by timeout
module reaction_round_sequencer #(
   parameter int unsigned BASE_DELAY_MS = 500,
   parameter int unsigned ROUNDS        = 3,
   parameter logic [15:0] TIMEOUT_BCD   = 16'h9999
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        tick_1k,
   input  logic        btn_press,
   input  logic [7:0]  rand_val,
   input  logic [15:0] bcd_time,
   output logic        cnt_go,
   output logic        cnt_clear,
   output logic        stim_led,
   output logic [2:0]  state_o,
   output logic [3:0]  round_o,
   output logic [15:0] last_time,
   output logic [15:0] best_time,
   output logic        false_start,
   output logic        miss
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_DELAY   = 3'd1,
      S_TIMING  = 3'd2,
      S_RESULT  = 3'd3,
      S_FALSE   = 3'd4,
      S_SUMMARY = 3'd5
   } state_t;

   localparam logic [15:0] BEST_INIT = 16'h9999;
   localparam logic [9:0]  BASE_W    = 10'(BASE_DELAY_MS);
   localparam logic [3:0]  ROUNDS_W  = 4'(ROUNDS);

   state_t      state_q, state_d;
   logic [3:0]  round_q, round_d;
   logic [15:0] last_q, last_d;
   logic [15:0] best_q, best_d;
   logic        miss_q, miss_d;
   logic [9:0]  dly_q, dly_d;
   logic [9:0]  dly_load;

   // Delay reload value used on every entry into DELAY.
   assign dly_load = BASE_W + {2'b00, rand_val};

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         round_q <= 4'd0;
         last_q  <= 16'h0000;
         best_q  <= BEST_INIT;
         miss_q  <= 1'b0;
         dly_q   <= 10'd0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         last_q  <= last_d;
         best_q  <= best_d;
         miss_q  <= miss_d;
         dly_q   <= dly_d;
      end
   end

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      last_d  = last_q;
      best_d  = best_q;
      miss_d  = miss_q;
      dly_d   = dly_q;
      case (state_q)
         S_IDLE: begin
            if (btn_press) begin
               state_d = S_DELAY;
               round_d = 4'd1;
               best_d  = BEST_INIT;
               miss_d  = 1'b0;
               dly_d   = dly_load;
            end
         end
         S_DELAY: begin
            // A press beats an expiry tick arriving in the same cycle.
            if (btn_press) begin
               state_d = S_FALSE;
            end else if (tick_1k) begin
               // <=1 rather than ==1 so a zero load cannot wrap the counter.
               if (dly_q <= 10'd1) begin
                  state_d = S_TIMING;
                  dly_d   = 10'd0;
               end else begin
                  dly_d   = dly_q - 10'd1;
               end
            end
         end
         S_TIMING: begin
            // A press coinciding with the timeout value is still a valid press.
            if (btn_press) begin
               state_d = S_RESULT;
               last_d  = bcd_time;
               miss_d  = 1'b0;
               if (bcd_time < best_q) begin
                  best_d = bcd_time;
               end
            end else if (bcd_time == TIMEOUT_BCD) begin
               state_d = S_RESULT;
               last_d  = TIMEOUT_BCD;
               miss_d  = 1'b1;
            end
         end
         S_RESULT: begin
            if (btn_press) begin
               if (round_q < ROUNDS_W) begin
                  state_d = S_DELAY;
                  round_d = round_q + 4'd1;
                  dly_d   = dly_load;
               end else begin
                  state_d = S_SUMMARY;
               end
            end
         end
         S_FALSE: begin
            // Retry the same round with a freshly sampled delay.
            if (btn_press) begin
               state_d = S_DELAY;
               dly_d   = dly_load;
            end
         end
         S_SUMMARY: begin
            if (btn_press) begin
               state_d = S_IDLE;
               round_d = 4'd0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign state_o     = state_q;
   assign round_o     = round_q;
   assign last_time   = last_q;
   assign best_time   = best_q;
   assign miss        = miss_q;
   assign cnt_clear   = (state_q == S_IDLE) || (state_q == S_DELAY) || (state_q == S_FALSE);
   assign cnt_go      = (state_q == S_TIMING);
   assign stim_led    = (state_q == S_TIMING);
   assign false_start = (state_q == S_FALSE);

endmodule
